// File: rtl/hs32_fetch_q.sv
// hs32_fetch_q -- instruction prefetch queue between the memory arbiter and decode.
//
// Issues pipelined word fetches (at most MAX_OUT in flight) and buffers the
// returned words, each tagged with its fetch PC, in a 1<<DEPTH_LOG2 entry FIFO.
// A flush redirects the PC and empties the FIFO without waiting for the bus:
// responses still in flight are counted as stale and discarded as they return.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   addr, reqm, ackm  fetch address / request valid / arbiter accept
//   dtr, rdym         response data / response valid (in issue order)
//   instd, pcd, rdyd  head instruction / its PC / head valid
//   reqd              decode pops the head when rdyd && reqd
//   newpc, flush      redirect target / redirect strobe
//   fetch_cnt, drop_cnt  (HS32_FETCH_STATS_EN only) pushed / discarded response counts
//
// Optional feature macro: HS32_FETCH_STATS_EN adds the statistics counters.
module hs32_fetch_q #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MAX_OUT    = 2,
  parameter int unsigned PC_STEP    = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      addr,
  output logic             reqm,
  input  logic             ackm,
  input  logic [WIDTH-1:0] dtr,
  input  logic             rdym,
  output logic [WIDTH-1:0] instd,
  output logic [31:0]      pcd,
  output logic             rdyd,
  input  logic             reqd,
  input  logic [31:0]      newpc,
  input  logic             flush
`ifdef HS32_FETCH_STATS_EN
  ,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      drop_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned TW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  // Advance a pc-tag queue pointer, wrapping at MAX_OUT (not necessarily a power of two).
  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    if (p == TW'(MAX_OUT - 1)) begin
      return {TW{1'b0}};
    end else begin
      return p + TW'(1);
    end
  endfunction

  logic [31:0]      pc_q, pc_d;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [PW-1:0]    ocnt_q, ocnt_d, stale_q, stale_d;
  logic [TW-1:0]    tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [31:0]      tag_mem_q  [MAX_OUT];
  logic [WIDTH-1:0] fifo_data_q[DEPTH];
  logic [31:0]      fifo_pc_q  [DEPTH];

  logic [PW-1:0]    fill_s;
  logic [PW:0]      credit_s;
  logic             issue_s, pop_s, push_s, drop_s;

  // Occupancy, credit check and the per-cycle events.
  always_comb begin
    fill_s   = wp_q - rp_q;
    // Slots already promised: buffered words plus live (non-stale) requests.
    credit_s = {1'b0, fill_s} + {1'b0, ocnt_q} - {1'b0, stale_q};
    reqm     = !rst && !flush && (credit_s < (PW + 1)'(DEPTH)) && (ocnt_q < PW'(MAX_OUT));
    issue_s  = reqm && ackm;
    rdyd     = (fill_s != {PW{1'b0}});
    pop_s    = rdyd && reqd && !flush;
    push_s   = rdym && !flush && (stale_q == {PW{1'b0}});
    drop_s   = rdym && (flush || (stale_q != {PW{1'b0}}));
    addr     = pc_q;
    instd    = fifo_data_q[rp_q[DEPTH_LOG2-1:0]];
    pcd      = fifo_pc_q[rp_q[DEPTH_LOG2-1:0]];
  end

  // Next-state computation for pointers, counters and PC.
  always_comb begin
    pc_d     = pc_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    ocnt_d   = ocnt_q;
    stale_d  = stale_q;
    tag_wp_d = tag_wp_q;
    tag_rp_d = tag_rp_q;

    case ({issue_s, rdym})
      2'b10:   ocnt_d = ocnt_q + PW'(1);
      2'b01:   ocnt_d = ocnt_q - PW'(1);
      default: ocnt_d = ocnt_q;
    endcase

    if (issue_s) begin
      tag_wp_d = tag_inc(tag_wp_q);
    end else begin
      tag_wp_d = tag_wp_q;
    end

    // Tags leave the queue with every response, stale or not, so they stay aligned with ocnt.
    if (rdym) begin
      tag_rp_d = tag_inc(tag_rp_q);
    end else begin
      tag_rp_d = tag_rp_q;
    end

    if (flush) begin
      pc_d    = newpc;
      wp_d    = {PW{1'b0}};
      rp_d    = {PW{1'b0}};
      // Everything still outstanding after this cycle belongs to the old stream.
      stale_d = ocnt_q - {{(PW - 1){1'b0}}, rdym};
    end else begin
      if (issue_s) begin
        pc_d = pc_q + 32'(PC_STEP);
      end else begin
        pc_d = pc_q;
      end
      if (push_s) begin
        wp_d = wp_q + PW'(1);
      end else begin
        wp_d = wp_q;
      end
      if (pop_s) begin
        rp_d = rp_q + PW'(1);
      end else begin
        rp_d = rp_q;
      end
      if (drop_s) begin
        stale_d = stale_q - PW'(1);
      end else begin
        stale_d = stale_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      wp_q     <= {PW{1'b0}};
      rp_q     <= {PW{1'b0}};
      ocnt_q   <= {PW{1'b0}};
      stale_q  <= {PW{1'b0}};
      tag_wp_q <= {TW{1'b0}};
      tag_rp_q <= {TW{1'b0}};
    end else begin
      pc_q     <= pc_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      ocnt_q   <= ocnt_d;
      stale_q  <= stale_d;
      tag_wp_q <= tag_wp_d;
      tag_rp_q <= tag_rp_d;
    end
  end

  // Storage for pc tags and buffered words; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      tag_mem_q[tag_wp_q] <= pc_q;
    end
    if (push_s) begin
      fifo_data_q[wp_q[DEPTH_LOG2-1:0]] <= dtr;
      fifo_pc_q[wp_q[DEPTH_LOG2-1:0]]   <= tag_mem_q[tag_rp_q];
    end
  end

`ifdef HS32_FETCH_STATS_EN
  logic [31:0] fetch_cnt_q, drop_cnt_q;

  // Wrapping statistics counters for pushed and discarded responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0000_0000;
      drop_cnt_q  <= 32'h0000_0000;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + {31'h0000_0000, push_s};
      drop_cnt_q  <= drop_cnt_q + {31'h0000_0000, drop_s};
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule
